// File: rtl/case_9_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : case_9_mul_pkg
// Description : Shared definitions for the case_9 pipelined multiplier.
//               Holds the mode encodings, the internal product-width helper
//               and the range-bound helpers used when narrowing results.
// Revision    : 1.0 - initial release
// ============================================================================
package case_9_mul_pkg;

    // Operand signedness modes; 2'b11 is handled the same as MODE_SS.
    localparam logic [1:0] MODE_SS = 2'b00;
    localparam logic [1:0] MODE_UU = 2'b01;
    localparam logic [1:0] MODE_SU = 2'b10;

    // Width in which every mode's product is exact: one spare bit lets an
    // unsigned x unsigned product be held as a non-negative signed value.
    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 1;
    endfunction

    // Largest signed value representable in w bits, as a bit pattern.
    function automatic logic [63:0] smax_bits(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Smallest signed value representable in w bits, as a w-bit pattern.
    function automatic logic [63:0] smin_bits(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // Largest unsigned value representable in w bits.
    function automatic logic [63:0] umax_bits(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/case_9_mul_narrow.sv
`default_nettype none
// ============================================================================
// Module      : case_9_mul_narrow
// Description : Combinational narrowing of an exact product to dout_WIDTH
//               bits, with overflow detection and optional saturation.
// Ports       : product (in,  PROD_WIDTH) exact two's-complement product
//               mode    (in,  2)          signedness mode of the item
//               dout    (out, dout_WIDTH) narrowed result
//               ovf     (out, 1)          product outside the result range
// Revision    : 1.0 - initial release
// ============================================================================
module case_9_mul_narrow
    import case_9_mul_pkg::*;
#(
    parameter int PROD_WIDTH = 15,
    parameter int dout_WIDTH = 7,
    parameter int SATURATE   = 0
) (
    input  logic [PROD_WIDTH-1:0] product,
    input  logic [1:0]            mode,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam logic [dout_WIDTH-1:0] c_SMAX = dout_WIDTH'(smax_bits(dout_WIDTH));
    localparam logic [dout_WIDTH-1:0] c_SMIN = dout_WIDTH'(smin_bits(dout_WIDTH));
    localparam logic [dout_WIDTH-1:0] c_UMAX = dout_WIDTH'(umax_bits(dout_WIDTH));

    logic                             w_unsigned;
    logic [PROD_WIDTH-dout_WIDTH:0]   w_hi_s;
    logic                             w_sovf;
    logic                             w_uovf;

    assign w_unsigned = (mode == MODE_UU);

    // Signed fit: every bit from the result sign bit upward must match.
    assign w_hi_s = product[PROD_WIDTH-1:dout_WIDTH-1];
    assign w_sovf = !((&w_hi_s) || !(|w_hi_s));

    // Unsigned fit: the product is never negative in this mode, so only
    // the bits above the result must be clear.
    assign w_uovf = |product[PROD_WIDTH-1:dout_WIDTH];

    always_comb begin
        ovf  = w_unsigned ? w_uovf : w_sovf;
        dout = product[dout_WIDTH-1:0];
        if ((SATURATE != 0) && ovf) begin
            if (w_unsigned) begin
                dout = c_UMAX;
            end else if (product[PROD_WIDTH-1]) begin
                dout = c_SMIN;
            end else begin
                dout = c_SMAX;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/case_9_mul_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module      : case_9_mul_pipe_hs
// Description : NUM_STAGE-deep pipelined multiplier with valid/ready
//               handshake, runtime signedness, wrap/saturate narrowing and
//               whole-pipeline stall on backpressure.
// Ports       : clk       (in,  1)          rising-edge clock
//               reset     (in,  1)          asynchronous active-high reset
//               in_valid  (in,  1)          din0/din1/mode valid
//               in_ready  (out, 1)          pipeline advances this cycle
//               din0      (in,  din0_WIDTH) operand 0
//               din1      (in,  din1_WIDTH) operand 1
//               mode      (in,  2)          00 ss, 01 uu, 10 su, 11 = ss
//               out_valid (out, 1)          dout/ovf hold a result
//               out_ready (in,  1)          consumer takes the result
//               dout      (out, dout_WIDTH) narrowed product
//               ovf       (out, 1)          product did not fit in dout
//               busy      (out, 1)          any slot holds a valid item
// Revision    : 1.0 - initial release
// ============================================================================
module case_9_mul_pipe_hs
    import case_9_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 7,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 7,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int c_PROD_WIDTH = prod_width(din0_WIDTH, din1_WIDTH);

    logic [NUM_STAGE-1:0]    r_valid;
    logic                    w_advance;

    // Operands feeding the multiplier (raw inputs or slot 0).
    logic [din0_WIDTH-1:0]   w_sa;
    logic [din1_WIDTH-1:0]   w_sb;
    logic [1:0]              w_sm;
    logic                    w_a_signed;
    logic                    w_b_signed;
    logic [c_PROD_WIDTH-1:0] w_ea;
    logic [c_PROD_WIDTH-1:0] w_eb;
    logic [c_PROD_WIDTH-1:0] w_prod;

    // Product and mode presented to the narrowing logic.
    logic [c_PROD_WIDTH-1:0] w_np;
    logic [1:0]              w_nm;
    logic [dout_WIDTH-1:0]   w_ndout;
    logic                    w_novf;

    logic [dout_WIDTH-1:0]   r_dout;
    logic                    r_ovf;

    // The whole pipeline moves together: any slot may be empty, and a stall
    // freezes bubbles as well as data so ordering and spacing are kept.
    assign w_advance = !r_valid[NUM_STAGE-1] || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_valid[NUM_STAGE-1];
    assign busy      = |r_valid;
    assign dout      = r_dout;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_advance) begin
            r_valid <= NUM_STAGE'({r_valid, in_valid});
        end
    end

    // With a single slot that slot is also the result slot, so the multiply
    // and narrowing run straight from the inputs; otherwise slot 0 captures
    // the raw operands and mode.
    if (NUM_STAGE == 1) begin : g_src_direct
        assign w_sa = din0;
        assign w_sb = din1;
        assign w_sm = mode;
    end else begin : g_src_slot0
        logic [din0_WIDTH-1:0] r_a;
        logic [din1_WIDTH-1:0] r_b;
        logic [1:0]            r_m;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_a <= '0;
                r_b <= '0;
                r_m <= '0;
            end else if (w_advance) begin
                r_a <= din0;
                r_b <= din1;
                r_m <= mode;
            end
        end

        assign w_sa = r_a;
        assign w_sb = r_b;
        assign w_sm = r_m;
    end

    // Mode 11 falls through to the signed x signed extension.
    assign w_a_signed = (w_sm != MODE_UU);
    assign w_b_signed = (w_sm != MODE_UU) && (w_sm != MODE_SU);
    assign w_ea = {{(c_PROD_WIDTH-din0_WIDTH){w_a_signed & w_sa[din0_WIDTH-1]}}, w_sa};
    assign w_eb = {{(c_PROD_WIDTH-din1_WIDTH){w_b_signed & w_sb[din1_WIDTH-1]}}, w_sb};

    // Both operands are extended to the full width, so the modular product
    // equals the exact signed product.
    assign w_prod = w_ea * w_eb;

    // Three or more slots: slot 1 registers the product, later middle slots
    // only delay it, and the last slot registers the narrowed result.
    if (NUM_STAGE <= 2) begin : g_nin_direct
        assign w_np = w_prod;
        assign w_nm = w_sm;
    end else begin : g_mid_slots
        logic [c_PROD_WIDTH-1:0] r_prod [1:NUM_STAGE-2];
        logic [1:0]              r_pm   [1:NUM_STAGE-2];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 1; i <= NUM_STAGE - 2; i++) begin
                    r_prod[i] <= '0;
                    r_pm[i]   <= '0;
                end
            end else if (w_advance) begin
                r_prod[1] <= w_prod;
                r_pm[1]   <= w_sm;
                for (int i = 2; i <= NUM_STAGE - 2; i++) begin
                    r_prod[i] <= r_prod[i-1];
                    r_pm[i]   <= r_pm[i-1];
                end
            end
        end

        assign w_np = r_prod[NUM_STAGE-2];
        assign w_nm = r_pm[NUM_STAGE-2];
    end

    case_9_mul_narrow #(
        .PROD_WIDTH (c_PROD_WIDTH),
        .dout_WIDTH (dout_WIDTH),
        .SATURATE   (SATURATE)
    ) u_narrow (
        .product (w_np),
        .mode    (w_nm),
        .dout    (w_ndout),
        .ovf     (w_novf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else if (w_advance) begin
            r_dout <= w_ndout;
            r_ovf  <= w_novf;
        end
    end

endmodule
`default_nettype wire

// File: doc/case_9_mul_pipe_hs.md
# case_9_mul_pipe_hs

Pipelined multiplier with a valid/ready handshake. It is the next generation of the case_9 combinational `mul_7s_7s_7` operator and adds:
- a parametrised pipeline depth and independent operand and result widths;
- runtime signedness selection;
- wrap or saturate narrowing, with an overflow flag;
- whole-pipeline backpressure stall.

It sits between HLS-generated datapath stages that need a multi-cycle multiply and cannot tolerate dropped results.

## Interface
- ID, 1: instance tag; no functional effect.
- NUM_STAGE, 3: latency in cycles from accept to out_valid; legal range 1..8.
- din0_WIDTH, 7: width of operand 0.
- din1_WIDTH, 7: width of operand 1.
- dout_WIDTH, 7: result width; legal range 1..din0_WIDTH+din1_WIDTH.
- SATURATE, 0: 0 = wrap (keep low bits); 1 = clamp to the representable range.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  din0/din1/mode are valid.
- in_ready  out  1  pipeline can advance this cycle.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- mode  in  2  00 = signed×signed; 01 = unsigned×unsigned; 10 = din0 signed × din1 unsigned; 11 = treated as 00.
- out_valid  out  1  dout/ovf hold a result.
- out_ready  in  1  consumer accepts the result.
- dout  out  dout_WIDTH  narrowed product.
- ovf  out  1  full product not representable in dout_WIDTH.
- busy  out  1  at least one pipeline slot holds a valid item.

## Operation
- Internal product width is P = din0_WIDTH+din1_WIDTH+1.
- Operand extension to P:
  - din0 is sign-extended in modes 00, 10 and 11; zero-extended in mode 01.
  - din1 is sign-extended in modes 00 and 11; zero-extended in modes 01 and 10.
- The full product is exact in P bits.
- Result range:
  - Signed range for modes 00, 10, 11: [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - Unsigned range for mode 01: [0, 2^dout_WIDTH-1].
- ovf = 1 when the full product lies outside that range.
- Narrowing:
  - SATURATE=0: dout = product[dout_WIDTH-1:0].
  - SATURATE=1: dout = nearest range bound on ovf, otherwise the low bits.
- ovf is reported in both narrowing modes.
- Pipeline: NUM_STAGE register slots, each carrying a valid bit plus data.
  - Slot 0 captures din0, din1 and mode on accept.
  - Multiply and narrowing logic may be placed in any slots, provided total latency is exactly NUM_STAGE.
- Advance signal: advance = !out_valid || out_ready; in_ready = advance.
  - in_ready depends combinationally on out_ready.
- Accept occurs when in_valid && in_ready.
  - On advance, every slot shifts forward.
  - Slot 0 valid = in_valid, so bubbles propagate as invalid slots.
- When advance = 0, all slots hold: dout, ovf and out_valid stay stable and the input is not accepted.
- out_valid is the valid bit of the last slot. busy = OR of all valid bits.

## Timing
- Reset, asynchronous and active-high, clears immediately:
  - all valid bits, out_valid, busy, dout and ovf to 0;
  - all data registers to 0.
- On release of reset, in_ready = 1.
- Reset asserted mid-operation discards every in-flight item; no partial result appears afterwards.
- With out_ready held high, an item accepted at edge k gives out_valid = 1 after edge k+NUM_STAGE.
  - Sustained throughput is one item per cycle.
- out_valid && !out_ready holds the entire pipeline, so nothing is lost or duplicated.
- A result is consumed at the edge where out_valid && out_ready; new data may replace it on the same edge.
- Bubbles do not collapse: a stall freezes empty slots too.
- mode is sampled only at accept; mode changes between items never affect in-flight items.

## Structure
- Shared package case_9_mul_pkg holds:
  - mode constants MODE_SS = 2'b00, MODE_UU = 2'b01, MODE_SU = 2'b10;
  - a P-width helper function;
  - range-bound helper functions for signed and unsigned dout_WIDTH.
- Sub-module case_9_mul_narrow (combinational):
  - inputs: P-bit product and mode;
  - outputs: dout and ovf;
  - one parameter: SATURATE.
  - It is instantiated once, in the last slot's input path.
- Top level holds the slot register arrays and the advance logic.

## Test plan
Vectors below use default widths (7/7/7) unless stated.
- Mode 00, din0=5 (0x05), din1=-3 (0x7D), SATURATE=0 → after 3 cycles, dout=0x71 (-15), ovf=0.
- Mode 00, din0=din1=0x40 (-64):
  - SATURATE=0 → dout=0x00, ovf=1.
  - SATURATE=1 → dout=0x3F, ovf=1.
- Mode 01, 0x7F×0x7F with SATURATE=1 → dout=0x7F, ovf=1.
- Mode 10, din0=0x7F (-1), din1=0x7F (127):
  - SATURATE=1 → dout=0x40, ovf=1.
  - SATURATE=0 → dout=0x01, ovf=1.
- Stream of 10 back-to-back items, with out_ready low for 4 cycles starting at cycle 5:
  - results appear in order, none lost or duplicated;
  - dout is stable while stalled;
  - in_ready=0 throughout the stall.
- Reset pulsed with 2 items in flight → out_valid=0 and busy=0 immediately, and no stale result afterwards. Repeat with NUM_STAGE=1 and a 16×12→26 configuration.
